// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : State encodings, grant selectors and width helper for mem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Brief  : Fetch port, load/store port and unified memory port bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    // master: the arbiter itself; slave: pipeline ports plus RAM around it
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// ============================================================================
// Module : arb_pick
// Brief  : Combinational D-priority pick with forced I grant on full streak.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_pick
    import mem_arbiter_pkg::*;
(
    input  wire logic i_eligible_i,
    input  wire logic i_eligible_d,
    input  wire logic i_streak_full,
    output logic      o_grant_valid,
    output logic      o_sel
);

    logic w_force_i;

    assign w_force_i     = i_eligible_i & i_streak_full;
    assign o_grant_valid = i_eligible_i | i_eligible_d;
    assign o_sel         = (i_eligible_d & ~w_force_i) ? SEL_D : SEL_I;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one req/ack RAM between fetch (I) and load/store (D) ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.master bus
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam int SW = cnt_width(MAX_D_STREAK);

    logic [1:0]    r_state;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_timer;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_ack;
    logic          r_i_err;
    logic [DW-1:0] r_i_rdata;
    logic          r_d_ack;
    logic          r_d_err;
    logic [DW-1:0] r_d_rdata;

    logic w_elig_i;
    logic w_elig_d;
    logic w_streak_full;
    logic w_grant_valid;
    logic w_sel;
    logic w_timeout_hit;

    // A port is not re-eligible in the cycle its own ack is still showing.
    assign w_elig_i      = bus.i_req & ~r_i_ack;
    assign w_elig_d      = bus.d_req & ~r_d_ack;
    assign w_streak_full = (r_streak == SW'(MAX_D_STREAK));

    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_timeout_hit = (r_timer == TW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    arb_pick u_pick (
        .i_eligible_i  (w_elig_i),
        .i_eligible_d  (w_elig_d),
        .i_streak_full (w_streak_full),
        .o_grant_valid (w_grant_valid),
        .o_sel         (w_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_timer     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_elig_i) begin
                        r_streak <= '0;
                    end
                    if (w_grant_valid) begin
                        r_mem_req <= 1'b1;
                        r_timer   <= '0;
                        if (w_sel == SEL_D) begin
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_state     <= ST_GRANT_D;
                            if (w_elig_i && !w_streak_full) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.i_addr;
                            r_mem_wdata <= '0;
                            r_state     <= ST_GRANT_I;
                            r_streak    <= '0;
                        end
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    // An ack landing on the timeout cycle still completes normally.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (r_state == ST_GRANT_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= bus.mem_rdata;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
                        end
                    end else if (w_timeout_hit) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (r_state == ST_GRANT_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= 1'b1;
                            r_i_rdata <= '0;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.i_err     = r_i_err;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;

endmodule

`default_nettype wire
